// File: rtl/dispense_arbiter_if.sv
// Handshake bundle between the channel FSMs / shared timer and the dispense arbiter.
// The arbiter takes the slave view; the channels and timer take the master view.
interface dispense_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] i_req;
  logic             i_end_count;
  logic             i_fault_clr;
  logic             o_start_count;
  logic [N_REQ-1:0] o_gnt;
  logic [W-1:0]     o_gnt_id;
  logic [N_REQ-1:0] o_done;
  logic             o_busy;
  logic             o_fault;
  logic [W-1:0]     o_fault_id;

  modport slave (
    input  i_req, i_end_count, i_fault_clr,
    output o_start_count, o_gnt, o_gnt_id, o_done, o_busy, o_fault, o_fault_id
  );

  modport master (
    output i_req, i_end_count, i_fault_clr,
    input  o_start_count, o_gnt, o_gnt_id, o_done, o_busy, o_fault, o_fault_id
  );
endinterface

// File: rtl/dispense_arbiter.sv
// Round-robin owner of the shared dispense timer: grants one channel at a time,
// sequences the timer start/end handshake and traps a timer that never expires.
module dispense_arbiter #(
  parameter int          N_REQ   = 4,
  parameter logic [31:0] TIMEOUT = 32'h0100_0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dispense_arbiter_if.slave  bus
);
  localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RUN,
    S_RELEASE,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     last_q, last_d;
  logic [31:0]      wd_q, wd_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]     gnt_id_q, gnt_id_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [W-1:0]     fault_id_q, fault_id_d;

  logic [W-1:0]     win_id;
  logic             win_vld;
  logic [31:0]      idx;

  // Search upward from the channel after the last one served, wrapping at N_REQ.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = k + {{(32-W){1'b0}}, last_q};
      if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
      if (!win_vld && bus.i_req[idx[W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wd_d       = wd_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    done_d     = '0;
    fault_d    = fault_q;
    fault_id_d = fault_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d          = S_GRANT;
          gnt_d            = '0;
          gnt_d[win_id]    = 1'b1;
          gnt_id_d         = win_id;
        end
      end
      S_GRANT: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + 32'd1;
        // Expiry takes precedence over the watchdog when both land together.
        if (bus.i_end_count) begin
          state_d = S_RELEASE;
          done_d  = gnt_q;
        end else if (wd_q == TIMEOUT - 32'd1) begin
          state_d    = S_FAULT;
          gnt_d      = '0;
          last_d     = gnt_id_q;
          fault_d    = 1'b1;
          fault_id_d = gnt_id_q;
        end
      end
      S_RELEASE: begin
        last_d  = gnt_id_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (bus.i_fault_clr) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state they describe.
    start_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      last_q     <= W'(N_REQ - 1);
      wd_q       <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      done_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_id_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wd_q       <= wd_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      done_q     <= done_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      fault_id_q <= fault_id_d;
    end
  end

  assign bus.o_start_count = start_q;
  assign bus.o_gnt         = gnt_q;
  assign bus.o_gnt_id      = gnt_id_q;
  assign bus.o_done        = done_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_fault       = fault_q;
  assign bus.o_fault_id    = fault_id_q;
endmodule
